intr_ctrl_multi: RTL and testbench

- Parametrised multi-source interrupt controller between external interrupt lines and the pipelined processor's single interrupt input.
- Replaces the processor's raw one-cycle interrupt pulse with a held request/acknowledge/end-of-interrupt handshake.
- Per source: edge capture into a pending register, plus a runtime-writable enable mask.
- Fixed-priority arbitration, with the lowest source index winning.
- Supplies a source id and a computed vector address to the processor.

---
 rtl/intr_ctrl_multi.sv | 129 ++++++++++++
 tb/tb_intr_ctrl_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl_multi.sv
// Multi-source interrupt controller: edge capture, enable mask, fixed-priority arbitration, held request handshake.
// Latency: irq_in rise -> pending at the next edge -> int_req one edge later (2 clocks total).
// Backpressure: the request is held until int_ack; no new request is raised until int_eoi returns to IDLE.
//
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   irq_in             - raw interrupt lines (synchronous to clk), captured on rising edge
//   mask_we, mask_in   - enable mask load strobe and value (1 = enabled)
//   int_ack, int_eoi   - processor accept and end-of-service strobes
//   int_req            - held interrupt request to the processor
//   int_id, int_vector - winning source index and its vector address
//   pending            - per-source pending bits (status)
//   in_service         - high while a service routine is running
module intr_ctrl_multi #(
    parameter int                    NUM_SRC    = 4,
    parameter int                    VEC_W      = 16,
    parameter logic [VEC_W-1:0]      BASE_VEC   = 16'h0002,
    parameter int                    VEC_STRIDE = 2,
    parameter logic [NUM_SRC-1:0]    MASK_RST   = '1,
    parameter int                    ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   irq_in,
    input  logic                 mask_we,
    input  logic [NUM_SRC-1:0]   mask_in,
    input  logic                 int_ack,
    input  logic                 int_eoi,
    output logic                 int_req,
    output logic [ID_W-1:0]      int_id,
    output logic [VEC_W-1:0]     int_vector,
    output logic [NUM_SRC-1:0]   pending,
    output logic                 in_service
);

    localparam int SUM_W = VEC_W + ID_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  irq_prev;
    logic [NUM_SRC-1:0]  mask;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  pending_nxt;
    logic [ID_W-1:0]     winner;

    // Vector arithmetic is done wide enough for the product, then wrapped to VEC_W.
    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(BASE_VEC) + SUM_W'(id) * SUM_W'(VEC_STRIDE);
        return sum[VEC_W-1:0];
    endfunction

    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending & mask;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Ack clears the in-flight source; a rise in the same cycle sets it again (set wins).
    always_comb begin
        pending_nxt = pending;
        if (state == ST_REQ && int_ack) begin
            pending_nxt[int_id] = 1'b0;
        end
        pending_nxt = pending_nxt | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            irq_prev   <= irq_in;   // a line already high at release is not an edge
            mask       <= MASK_RST;
            pending    <= '0;
            int_req    <= 1'b0;
            in_service <= 1'b0;
            int_id     <= '0;
            int_vector <= BASE_VEC;
        end else begin
            irq_prev <= irq_in;
            pending  <= pending_nxt;
            if (mask_we) begin
                mask <= mask_in;
            end
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        int_id     <= winner;
                        int_vector <= vec_of(winner);
                        int_req    <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // id/vector stay frozen here; a higher-priority arrival waits its turn.
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (int_eoi) begin
                        in_service <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl_multi.sv
module tb_intr_ctrl_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_in = '0;
    logic        int_ack = 1'b0;
    logic        int_eoi = 1'b0;
    logic        int_req;
    logic [1:0]  int_id;
    logic [15:0] int_vector;
    logic [3:0]  pending;
    logic        in_service;

    intr_ctrl_multi #(
        .NUM_SRC(4), .VEC_W(16), .BASE_VEC(16'h0002), .VEC_STRIDE(2),
        .MASK_RST(4'b1111), .ID_W(2)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
        .mask_in(mask_in), .int_ack(int_ack), .int_eoi(int_eoi),
        .int_req(int_req), .int_id(int_id), .int_vector(int_vector),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [1:0]  id;
        logic [15:0] vec;
        logic [3:0]  pend;
        logic        svc;
    } snap_t;

    snap_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    // Reference model: what the controller is doing, in plain terms.
    bit    m_prev[4];
    bit    m_pend[4];
    bit    m_mask[4];
    int    m_phase;      // 0 = nothing outstanding, 1 = waiting for ack, 2 = routine running
    int    m_id;

    task automatic model_step(input logic rst, input logic [3:0] irq, input logic mwe,
                              input logic [3:0] min, input logic ack, input logic eoi);
        int  win;
        bit  cleared;
        snap_t e;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = irq[i];
                m_pend[i] = 0;
                m_mask[i] = 1;
            end
            m_phase = 0;
            m_id    = 0;
        end else begin
            win = -1;
            for (int i = 0; i < 4; i++)
                if (win < 0 && m_pend[i] && m_mask[i]) win = i;
            cleared = (m_phase == 1) && ack;
            for (int i = 0; i < 4; i++)
                m_pend[i] = (m_pend[i] && !(cleared && i == m_id)) || (irq[i] && !m_prev[i]);
            if (m_phase == 0) begin
                if (win >= 0) begin
                    m_id    = win;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ack) m_phase = 2;
            end else begin
                if (eoi) m_phase = 0;
            end
            if (mwe)
                for (int i = 0; i < 4; i++) m_mask[i] = min[i];
            for (int i = 0; i < 4; i++) m_prev[i] = irq[i];
        end
        e.req  = (m_phase == 1);
        e.svc  = (m_phase == 2);
        e.id   = 2'(m_id);
        e.vec  = 16'((2 + 2 * m_id) % 65536);
        for (int i = 0; i < 4; i++) e.pend[i] = m_pend[i];
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock of stimulus: drive at the falling edge and record the expected post-edge state.
    task automatic cyc(input logic [3:0] irq, input logic ack = 0, input logic eoi = 0,
                       input logic mwe = 0, input logic [3:0] min = 4'b0, input logic rst = 0);
        @(negedge clk);
        irq_in  = irq;
        int_ack = ack;
        int_eoi = eoi;
        mask_we = mwe;
        mask_in = min;
        reset   = rst;
        model_step(rst, irq, mwe, min, ack, eoi);
    endtask

    task automatic quiet(input int n, input logic [3:0] irq = 4'b0);
        for (int i = 0; i < n; i++) cyc(irq);
    endtask

    // Look at the DUT just after the edge that consumed the last cyc().
    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a queued expectation is compared in full.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {int_req, int_id, int_vector, pending, in_service};
                n_chk++;
                if (a === e) n_pass++;
                else $display("FAIL sb@%0t: got req=%b id=%0d vec=%h pend=%b svc=%b, expected req=%b id=%0d vec=%h pend=%b svc=%b",
                              $time, a.req, a.id, a.vec, a.pend, a.svc, e.req, e.id, e.vec, e.pend, e.svc);
            end
        end
    end

    initial begin
        logic [3:0] r_irq;
        // Reset with line 0 held high through release.
        cyc(4'b0001, 0, 0, 0, 4'b0, 1);
        peek();
        chk("rst_req", int_req, 0);
        chk("rst_vec", int_vector, 16'h0002);
        chk("rst_pend", pending, 0);
        quiet(10, 4'b0001);
        peek();
        chk("held_no_req", int_req, 0);
        chk("held_no_pend", pending, 0);

        // Single event and full handshake.
        cyc(4'b0100);
        peek();
        chk("single_pend", pending, 4'b0100);
        chk("single_req_early", int_req, 0);
        cyc(4'b0000);
        peek();
        chk("single_req", int_req, 1);
        chk("single_id", int_id, 2);
        chk("single_vec", int_vector, 16'h0006);
        quiet(2);
        cyc(4'b0000, 1);
        peek();
        chk("ack_req", int_req, 0);
        chk("ack_svc", in_service, 1);
        chk("ack_pend", pending, 0);
        cyc(4'b0000, 0, 1);
        peek();
        chk("eoi_svc", in_service, 0);

        // Priority and freeze.
        cyc(4'b1010);
        cyc(4'b0000);
        peek();
        chk("prio_id", int_id, 1);
        chk("prio_vec", int_vector, 16'h0004);
        cyc(4'b0001);
        cyc(4'b0000);
        peek();
        chk("freeze_id", int_id, 1);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000);
        peek();
        chk("next_id0", int_id, 0);
        chk("next_req0", int_req, 1);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000);
        peek();
        chk("next_id3", int_id, 3);
        chk("next_vec3", int_vector, 16'h0008);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0, 1);

        // Masked source stays pending, then requests once enabled.
        cyc(4'b0000, 0, 0, 1, 4'b1110);
        cyc(4'b0001);
        quiet(8);
        peek();
        chk("mask_pend", pending[0], 1);
        chk("mask_no_req", int_req, 0);
        cyc(4'b0000, 0, 0, 1, 4'b1111);
        cyc(4'b0000);
        peek();
        chk("unmask_req", int_req, 1);
        chk("unmask_id", int_id, 0);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0, 1);

        // Rise on the acked source in the ack cycle: set wins.
        cyc(4'b0100);
        cyc(4'b0000);
        cyc(4'b0100, 1);
        peek();
        chk("retrig_pend", pending[2], 1);
        chk("retrig_svc", in_service, 1);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000);
        peek();
        chk("retrig_req", int_req, 1);
        chk("retrig_id", int_id, 2);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000, 0, 1);
        peek();
        chk("idle_eoi_req", int_req, 0);
        chk("idle_eoi_svc", in_service, 0);

        // Reset while a routine runs with source 3 pending again.
        cyc(4'b1000);
        cyc(4'b0000);
        cyc(4'b0000, 1);
        cyc(4'b1000);
        peek();
        chk("pre_rst_svc", in_service, 1);
        chk("pre_rst_pend", pending, 4'b1000);
        cyc(4'b0000, 0, 0, 0, 4'b0, 1);
        peek();
        chk("mid_rst_svc", in_service, 0);
        chk("mid_rst_pend", pending, 0);
        chk("mid_rst_id", int_id, 0);
        quiet(5);
        peek();
        chk("post_rst_req", int_req, 0);

        // Randomised traffic against the model.
        r_irq = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) r_irq[b] = ~r_irq[b];
            cyc(r_irq,
                $urandom_range(2) == 0,
                $urandom_range(3) == 0,
                $urandom_range(19) == 0,
                4'($urandom_range(15)),
                $urandom_range(199) == 0);
        end
        peek();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
